crc16_serial_check: RTL and testbench

Serial CRC-16 checker; the receive-side counterpart of the serial CRC-16 encoder. Consumes the encoder's output stream: data bits, then 16 CRC bits MSB first. Recomputes the CRC over the data bits with generator x^16+x^15+x^2+1 (0x8005) and initial value 0, then compares it with the received CRC field. Reports a per-frame pass/fail result to the link-layer controller.

---
 rtl/crc16_pkg.sv | 23 ++
 rtl/crc16_serial_check_if.sv | 45 ++++
 rtl/crc16_serial_lfsr.sv | 24 ++
 rtl/crc16_serial_check.sv | 181 ++++++++++++++++++
 tb/tb_crc16_serial_check.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc16_pkg.sv
// Shared CRC-16 (x^16+x^15+x^2+1) constants, FSM state type and LFSR step
// function used by the serial CRC-16 checker and encoder.
package crc16_pkg;

  localparam int          CRC16_W    = 16;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [CRC16_W-1:0] crc16_step(input logic [CRC16_W-1:0] crc,
                                                     input logic               b);
    logic fb;
    fb = crc[CRC16_W-1] ^ b;
    return {crc[CRC16_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial_check_if.sv
// Stream and result signals of the serial CRC-16 checker.
// Optional byte output ports exist only when CRC16_CHECK_BYTE_OUT_EN is defined.
interface crc16_serial_check_if #(
  parameter int LEN_W = 16
);
  import crc16_pkg::*;

  // Stream: a bit is transferred on every rising edge where bit_valid=1; there is
  // no backpressure. start/data_last are only sampled together with bit_valid.
  logic              start;
  logic              bit_valid;
  logic              bit_in;
  logic              data_last;

  logic              busy;
  logic              done;
  logic              crc_ok;
  logic              crc_err;
  logic              len_err;
  logic [15:0]       calc_crc;
  logic [15:0]       rx_crc;
  logic [LEN_W-1:0]  data_len;
  state_e            state;
`ifdef CRC16_CHECK_BYTE_OUT_EN
  logic [7:0]        data_byte;
  logic              byte_valid;
`endif

  modport master (
    output start, bit_valid, bit_in, data_last,
    input  busy, done, crc_ok, crc_err, len_err, calc_crc, rx_crc, data_len, state
`ifdef CRC16_CHECK_BYTE_OUT_EN
    , input data_byte, byte_valid
`endif
  );

  modport slave (
    input  start, bit_valid, bit_in, data_last,
    output busy, done, crc_ok, crc_err, len_err, calc_crc, rx_crc, data_len, state
`ifdef CRC16_CHECK_BYTE_OUT_EN
    , output data_byte, byte_valid
`endif
  );

endinterface

// File: rtl/crc16_serial_lfsr.sv
// 16-bit serial CRC register: clr restarts from CRC16_INIT, en absorbs bit_in.
// With clr and en together the bit is absorbed into a freshly cleared register.
module crc16_serial_lfsr
  import crc16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               bit_in,
  output logic [CRC16_W-1:0] crc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(clr ? CRC16_INIT : crc, bit_in);
    end else if (clr) begin
      crc <= CRC16_INIT;
    end
  end

endmodule

// File: rtl/crc16_serial_check.sv
// Serial CRC-16 checker: recomputes the CRC over the data bits and compares it
// with the trailing 16-bit field. Byte output enabled by CRC16_CHECK_BYTE_OUT_EN.
module crc16_serial_check
  import crc16_pkg::*;
#(
  parameter int MAX_DATA_BITS = 4096,
  parameter int LEN_W         = 16
)(
  input  logic clk,
  input  logic rst,
  crc16_serial_check_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_BITS);

  state_e               state, state_next;
  logic                 accept;
  logic                 lfsr_clr;
  logic                 lfsr_en;
  logic                 ovf_hit;
  logic [CRC16_W-1:0]   lfsr;
  logic [3:0]           crc_cnt;
  logic [LEN_W-1:0]     data_len;
  logic [CRC16_W-1:0]   rx_crc;
  logic                 ovf;
  logic                 busy_q;
  logic                 done_q;
  logic                 crc_ok_q;
  logic                 crc_err_q;
  logic                 len_err_q;

  crc16_serial_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .clr    (lfsr_clr),
    .en     (lfsr_en),
    .bit_in (bus.bit_in),
    .crc    (lfsr)
  );

  assign accept = (state == IDLE) && bus.start && bus.bit_valid;

  always_comb begin
    state_next = state;
    lfsr_clr   = 1'b0;
    lfsr_en    = 1'b0;
    ovf_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          lfsr_clr   = 1'b1;
          lfsr_en    = 1'b1;
          state_next = bus.data_last ? CRC : DATA;
        end
      end
      DATA: begin
        if (bus.bit_valid) begin
          // A bit beyond MAX_DATA_BITS aborts the frame even if it carries data_last.
          if (data_len == MAX_LEN) begin
            ovf_hit    = 1'b1;
            state_next = DONE;
          end else begin
            lfsr_en = 1'b1;
            if (bus.data_last) state_next = CRC;
          end
        end
      end
      CRC: begin
        if (bus.bit_valid && (crc_cnt == 4'd15)) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      ovf       <= 1'b0;
      crc_cnt   <= 4'd0;
      data_len  <= '0;
      rx_crc    <= '0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      done_q <= (state == DONE);
      if (accept) begin
        data_len  <= LEN_W'(1);
        rx_crc    <= '0;
        crc_ok_q  <= 1'b0;
        crc_err_q <= 1'b0;
        len_err_q <= 1'b0;
        ovf       <= 1'b0;
        crc_cnt   <= 4'd0;
      end else begin
        case (state)
          DATA: begin
            if (ovf_hit)      ovf      <= 1'b1;
            else if (lfsr_en) data_len <= data_len + LEN_W'(1);
          end
          CRC: begin
            if (bus.bit_valid) begin
              rx_crc  <= {rx_crc[CRC16_W-2:0], bus.bit_in};
              crc_cnt <= crc_cnt + 4'd1;
            end
          end
          DONE: begin
            if (ovf) begin
              len_err_q <= 1'b1;
              crc_err_q <= 1'b1;
              crc_ok_q  <= 1'b0;
            end else begin
              crc_ok_q  <= (rx_crc == lfsr);
              crc_err_q <= (rx_crc != lfsr);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crc_ok   = crc_ok_q;
  assign bus.crc_err  = crc_err_q;
  assign bus.len_err  = len_err_q;
  assign bus.calc_crc = lfsr;
  assign bus.rx_crc   = rx_crc;
  assign bus.data_len = data_len;
  assign bus.state    = state;

`ifdef CRC16_CHECK_BYTE_OUT_EN
  logic [7:0] byte_acc;
  logic [2:0] byte_cnt;
  logic [2:0] byte_base;
  logic [7:0] byte_next;
  logic       byte_emit;
  logic [7:0] data_byte_q;
  logic       byte_valid_q;

  // Accepted start restarts the deserializer with the frame's first bit.
  assign byte_base = lfsr_clr ? 3'd0 : byte_cnt;
  assign byte_next = (lfsr_clr ? 8'h00 : byte_acc) | ({bus.bit_in, 7'b0} >> byte_base);
  assign byte_emit = bus.data_last || (byte_base == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_acc     <= 8'h00;
      byte_cnt     <= 3'd0;
      data_byte_q  <= 8'h00;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (lfsr_en) begin
        if (byte_emit) begin
          data_byte_q  <= byte_next;
          byte_valid_q <= 1'b1;
          byte_acc     <= 8'h00;
          byte_cnt     <= 3'd0;
        end else begin
          byte_acc <= byte_next;
          byte_cnt <= byte_base + 3'd1;
        end
      end else if (lfsr_clr) begin
        byte_acc <= 8'h00;
        byte_cnt <= 3'd0;
      end
    end
  end

  assign bus.data_byte  = data_byte_q;
  assign bus.byte_valid = byte_valid_q;
`endif

endmodule

// File: tb/tb_crc16_serial_check.sv
// Bench for crc16_serial_check: two instances (default and MAX_DATA_BITS=16) share one
// randomized stream and are checked against a polynomial-division CRC model.
module tb_crc16_serial_check;
  import crc16_pkg::*;

  localparam int LEN_W     = 16;
  localparam int BIG_MAX   = 4096;
  localparam int SMALL_MAX = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc16_serial_check_if #(.LEN_W(LEN_W)) m_if();
  crc16_serial_check_if #(.LEN_W(LEN_W)) s_if();

  crc16_serial_check #(.MAX_DATA_BITS(BIG_MAX), .LEN_W(LEN_W)) dut (
    .clk (clk), .rst (rst), .bus (m_if.slave)
  );
  crc16_serial_check #(.MAX_DATA_BITS(SMALL_MAX), .LEN_W(LEN_W)) dut_small (
    .clk (clk), .rst (rst), .bus (s_if.slave)
  );

  assign s_if.start     = m_if.start;
  assign s_if.bit_valid = m_if.bit_valid;
  assign s_if.bit_in    = m_if.bit_in;
  assign s_if.data_last = m_if.data_last;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int               cnt;
    int               cyc;
    logic             ok;
    logic             err;
    logic             lerr;
    logic [15:0]      calc;
    logic [15:0]      rx;
    logic [LEN_W-1:0] len;
  } res_t;

  res_t m_res = '{default: 0};
  res_t s_res = '{default: 0};

  bit   frm[$];
  int   bit_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (m_if.done) begin
      m_res.cnt  = m_res.cnt + 1;
      m_res.cyc  = cyc;
      m_res.ok   = m_if.crc_ok;
      m_res.err  = m_if.crc_err;
      m_res.lerr = m_if.len_err;
      m_res.calc = m_if.calc_crc;
      m_res.rx   = m_if.rx_crc;
      m_res.len  = m_if.data_len;
    end
    if (s_if.done) begin
      s_res.cnt  = s_res.cnt + 1;
      s_res.cyc  = cyc;
      s_res.ok   = s_if.crc_ok;
      s_res.err  = s_if.crc_err;
      s_res.lerr = s_if.len_err;
      s_res.calc = s_if.calc_crc;
      s_res.rx   = s_if.rx_crc;
      s_res.len  = s_if.data_len;
    end
`ifdef CRC16_CHECK_BYTE_OUT_EN
    if (m_if.byte_valid) got_q.push_back(m_if.data_byte);
`endif
  end

  // ---------------- reference model ----------------
  // Remainder of M(x)*x^16 divided by x^16+x^15+x^2+1, over the first n frame bits.
  function automatic logic [15:0] ref_crc(input int n);
    logic [16:0] rem;
    rem = 17'h0;
    for (int i = 0; i < n + 16; i++) begin
      rem = {rem[15:0], (i < n) ? frm[i] : 1'b0};
      if (rem[16]) rem = rem ^ 17'h18005;
    end
    return rem[15:0];
  endfunction

  task automatic check_res(input string tag, input res_t r, input int cnt0,
                           input int max_bits, input logic [15:0] crc_field);
    int          n;
    bit          ovf;
    int          eff;
    logic [15:0] e_calc;
    logic [15:0] e_rx;
    logic        e_ok;
    n      = frm.size();
    ovf    = (n > max_bits);
    eff    = ovf ? max_bits : n;
    e_calc = ref_crc(eff);
    e_rx   = ovf ? 16'h0 : crc_field;
    e_ok   = !ovf && (e_calc == crc_field);
    check({tag, ".done_cnt"}, r.cnt - cnt0, 1);
    check({tag, ".done_cyc"}, r.cyc, (ovf ? bit_cyc[max_bits] : bit_cyc[n + 15]) + 1);
    check({tag, ".crc_ok"},   r.ok,   e_ok);
    check({tag, ".crc_err"},  r.err,  !e_ok);
    check({tag, ".len_err"},  r.lerr, ovf);
    check({tag, ".calc_crc"}, r.calc, e_calc);
    check({tag, ".rx_crc"},   r.rx,   e_rx);
    check({tag, ".data_len"}, r.len,  eff);
  endtask

  // ---------------- driver ----------------
  task automatic load_str(input string s);
    logic [7:0] c;
    frm.delete();
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      for (int b = 7; b >= 0; b--) frm.push_back(c[b]);
    end
  endtask

  task automatic idle_cycle();
    m_if.bit_valid = 1'b0;
    m_if.start     = 1'($urandom_range(1));
    m_if.data_last = 1'($urandom_range(1));
    m_if.bit_in    = 1'($urandom_range(1));
    @(posedge clk); #1;
  endtask

  // Sends frm followed by crc_field; abort_at >= 0 pulls reset after that many bits.
  task automatic run_frame(input string tag, input int gap_pct,
                           input logic [15:0] crc_field, input int abort_at);
    int n;
    int g;
    int m_cnt0;
    int s_cnt0;
    int got0;
    n      = frm.size();
    m_cnt0 = m_res.cnt;
    s_cnt0 = s_res.cnt;
    got0   = got_q.size();
    bit_cyc.delete();
    for (int i = 0; i < n + 16; i++) begin
      if (i == abort_at) break;
      g = 0;
      while (g < 8 && $urandom_range(99) < gap_pct) begin
        idle_cycle();
        g++;
      end
      m_if.bit_valid = 1'b1;
      m_if.start     = (i == 0);
      m_if.bit_in    = (i < n) ? frm[i] : crc_field[15 - (i - n)];
      m_if.data_last = (i == n - 1) || ((i >= n) && ($urandom_range(1) == 1));
      @(posedge clk); #1;
      bit_cyc.push_back(cyc);
    end
    m_if.bit_valid = 1'b0;
    m_if.start     = 1'b0;
    m_if.data_last = 1'b0;
    if (abort_at >= 0) begin
      #1 rst = 1'b0;
      #1;
      check({tag, ".rst_busy"},    m_if.busy,     0);
      check({tag, ".rst_done"},    m_if.done,     0);
      check({tag, ".rst_ok"},      m_if.crc_ok,   0);
      check({tag, ".rst_err"},     m_if.crc_err,  0);
      check({tag, ".rst_lerr"},    m_if.len_err,  0);
      check({tag, ".rst_calc"},    m_if.calc_crc, 0);
      check({tag, ".rst_rx"},      m_if.rx_crc,   0);
      check({tag, ".rst_len"},     m_if.data_len, 0);
      check({tag, ".rst_s_busy"},  s_if.busy,     0);
      #3 rst = 1'b1;
      @(posedge clk); #1;
    end else begin
      check({tag, ".done_early"}, m_if.done, 0);
      @(posedge clk); #1;
      check({tag, ".done_lat"}, m_if.done, 1);
      @(posedge clk); #1;
      check({tag, ".hold_ok"}, m_if.crc_ok, (ref_crc(n) == crc_field));
      check({tag, ".idle_busy"}, m_if.busy, 0);
      check_res({tag, ".big"},   m_res, m_cnt0, BIG_MAX,   crc_field);
      check_res({tag, ".small"}, s_res, s_cnt0, SMALL_MAX, crc_field);
`ifdef CRC16_CHECK_BYTE_OUT_EN
      exp_q.delete();
      for (int i = 0; i < n; i += 8) begin
        logic [7:0] b;
        b = 8'h00;
        for (int j = 0; j < 8 && i + j < n; j++) b[7 - j] = frm[i + j];
        exp_q.push_back(b);
      end
      check({tag, ".byte_cnt"}, got_q.size() - got0, exp_q.size());
      for (int i = 0; i < exp_q.size() && got0 + i < got_q.size(); i++)
        check({tag, ".byte"}, got_q[got0 + i], exp_q[i]);
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] fld;
    int          n;
    rst            = 1'b0;
    m_if.start     = 1'b0;
    m_if.bit_valid = 1'b0;
    m_if.bit_in    = 1'b0;
    m_if.data_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy",     m_if.busy,     0);
    check("reset.done",     m_if.done,     0);
    check("reset.crc_ok",   m_if.crc_ok,   0);
    check("reset.crc_err",  m_if.crc_err,  0);
    check("reset.len_err",  m_if.len_err,  0);
    check("reset.calc_crc", m_if.calc_crc, 0);
    check("reset.rx_crc",   m_if.rx_crc,   0);
    check("reset.data_len", m_if.data_len, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) idle_cycle();

    load_str("123456789");
    run_frame("ascii", 0, 16'hFEE8, -1);
    check("ascii.calc_const", m_if.calc_crc, 16'hFEE8);
    check("ascii.ok_const",   m_if.crc_ok,   1);

    frm[5] = !frm[5];
    run_frame("flip5", 0, 16'hFEE8, -1);
    check("flip5.err_const", m_if.crc_err, 1);

    frm.delete();
    frm.push_back(1'b1);
    run_frame("one_bit", 0, 16'h8005, -1);
    check("one_bit.ok_const", m_if.crc_ok, 1);

    load_str("123456789");
    run_frame("ascii_gaps", 50, 16'hFEE8, -1);

    frm.delete();
    for (int i = 0; i < 17; i++) frm.push_back(1'($urandom_range(1)));
    run_frame("len17", 30, ref_crc(17), -1);
    check("len17.small_lerr_const", s_if.len_err, 1);
    load_str(" ");
    frm.delete();
    for (int i = 0; i < 8; i++) frm.push_back(1'b0);
    run_frame("zero_byte", 0, 16'h0000, -1);
    check("zero_byte.small_ok_const", s_if.crc_ok, 1);

    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(1, 40);
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back(1'($urandom_range(1)));
      fld = ($urandom_range(1) == 1) ? ref_crc(n) : 16'($urandom);
      run_frame("rand", $urandom_range(0, 60), fld, -1);
      if ($urandom_range(1) == 1) idle_cycle();
    end

    load_str("123456789");
    run_frame("abort", 0, 16'hFEE8, 72 + 5);
    run_frame("after_abort", 20, 16'hFEE8, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
